// File: rtl/seq_pkg.sv
// Shared types and program start-address table for the run sequencer.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN,
    REPORT
  } seq_state_t;

  localparam int unsigned PROG_ADDR [8] = '{0, 64, 128, 0, 0, 0, 0, 0};

endpackage

// File: rtl/prog_sequencer_if.sv
// Host/core-facing signal bundle of the run sequencer.
interface prog_sequencer_if #(
  parameter int D  = 12,
  parameter int PW = 3,
  parameter int CW = 16
) ();

  logic          go;
  logic          core_done;
  logic          core_start;
  logic [D-1:0]  start_address;
  logic [PW-1:0] prog_idx;
  logic [CW-1:0] cyc_count;
  logic          rpt_valid;
  logic          rpt_timeout;
  logic          busy;
  logic          all_done;

  modport master (
    output go, core_done,
    input  core_start, start_address, prog_idx, cyc_count,
    input  rpt_valid, rpt_timeout, busy, all_done
  );

  modport slave (
    input  go, core_done,
    output core_start, start_address, prog_idx, cyc_count,
    output rpt_valid, rpt_timeout, busy, all_done
  );

endinterface

// File: rtl/prog_addr_lut.sv
// Combinational map from program index to program start PC.
module prog_addr_lut
  import seq_pkg::*;
#(
  parameter int D     = 12,
  parameter int NPROG = 3,
  parameter int PW    = 3
) (
  input  logic [PW-1:0] idx_i,
  output logic [D-1:0]  addr_o
);

  // Indices at or above NPROG fall through to address 0.
  always_comb begin
    addr_o = '0;
    for (int i = 0; i < NPROG; i++) begin
      if (idx_i == PW'(i)) addr_o = D'(PROG_ADDR[i]);
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Launches NPROG programs back to back on the core, timing each run with a
// watchdog and emitting one report pulse per program.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int          D         = 12,
  parameter int          NPROG     = 3,
  parameter int          PW        = 3,
  parameter int          CW        = 16,
  parameter int          START_CYC = 2,
  parameter int unsigned TIMEOUT   = 2**CW - 1
) (
  input logic             clk,
  input logic             rst_n,
  prog_sequencer_if.slave bus
);

  localparam int            LW          = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [LW-1:0] LAUNCH_LAST = LW'(START_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_CW  = CW'(TIMEOUT);
  localparam logic [PW-1:0] LAST_IDX    = PW'(NPROG - 1);
  localparam logic [D-1:0]  ADDR_RESET  = D'(PROG_ADDR[0]);

  seq_state_t    state_q;
  logic [LW-1:0] launch_ctr_q;
  logic [PW-1:0] prog_idx_q, prog_idx_d;
  logic [CW-1:0] cyc_count_q;
  logic [CW-1:0] cyc_inc;
  logic [D-1:0]  start_address_q;
  logic [D-1:0]  lut_addr;
  logic          core_start_q;
  logic          rpt_valid_q;
  logic          rpt_timeout_q;
  logic          busy_q;
  logic          all_done_q;

  assign cyc_inc = cyc_count_q + CW'(1);

  // The address register follows the index it will hold after this edge.
  always_comb begin
    prog_idx_d = prog_idx_q;
    if (state_q == IDLE && bus.go)
      prog_idx_d = '0;
    else if (state_q == REPORT && prog_idx_q != LAST_IDX)
      prog_idx_d = prog_idx_q + PW'(1);
  end

  prog_addr_lut #(
    .D     (D),
    .NPROG (NPROG),
    .PW    (PW)
  ) u_lut (
    .idx_i  (prog_idx_d),
    .addr_o (lut_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      launch_ctr_q    <= '0;
      prog_idx_q      <= '0;
      cyc_count_q     <= '0;
      start_address_q <= ADDR_RESET;
      core_start_q    <= 1'b1;
      rpt_valid_q     <= 1'b0;
      rpt_timeout_q   <= 1'b0;
      busy_q          <= 1'b0;
      all_done_q      <= 1'b0;
    end else begin
      prog_idx_q      <= prog_idx_d;
      start_address_q <= lut_addr;
      rpt_valid_q     <= 1'b0;
      rpt_timeout_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.go) begin
            cyc_count_q  <= '0;
            all_done_q   <= 1'b0;
            busy_q       <= 1'b1;
            launch_ctr_q <= '0;
            state_q      <= LAUNCH;
          end
        end
        LAUNCH: begin
          // core_done may still be high from the previous program; not looked at here.
          if (launch_ctr_q == LAUNCH_LAST) begin
            launch_ctr_q <= '0;
            core_start_q <= 1'b0;
            state_q      <= RUN;
          end else begin
            launch_ctr_q <= launch_ctr_q + LW'(1);
          end
        end
        RUN: begin
          cyc_count_q <= cyc_inc;
          if (bus.core_done || cyc_inc == TIMEOUT_CW) begin
            rpt_valid_q   <= 1'b1;
            rpt_timeout_q <= ~bus.core_done;
            core_start_q  <= 1'b1;
            state_q       <= REPORT;
          end
        end
        REPORT: begin
          if (prog_idx_q == LAST_IDX) begin
            all_done_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            cyc_count_q  <= '0;
            launch_ctr_q <= '0;
            state_q      <= LAUNCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.core_start    = core_start_q;
  assign bus.start_address = start_address_q;
  assign bus.prog_idx      = prog_idx_q;
  assign bus.cyc_count     = cyc_count_q;
  assign bus.rpt_valid     = rpt_valid_q;
  assign bus.rpt_timeout   = rpt_timeout_q;
  assign bus.busy          = busy_q;
  assign bus.all_done      = all_done_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a cycle timeline built from per-program latencies
// is compared against the DUT every cycle, plus literal report checks.
module tb_prog_sequencer;

  localparam int D         = 12;
  localparam int NPROG     = 3;
  localparam int PW        = 3;
  localparam int CW        = 16;
  localparam int START_CYC = 2;
  localparam int TIMEOUT   = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_sequencer_if #(.D(D), .PW(PW), .CW(CW)) bus ();

  prog_sequencer #(
    .D         (D),
    .NPROG     (NPROG),
    .PW        (PW),
    .CW        (CW),
    .START_CYC (START_CYC),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  int EXP_ADDR [NPROG] = '{0, 64, 128};

  typedef struct {
    bit done_in;
    bit go_in;
    bit cs;
    bit busy;
    bit rv;
    bit rt;
    int idx;
    int cyc;
    bit ad;
    int addr;
  } cyc_rec_t;

  typedef struct {
    int idx;
    int cyc;
    int to;
    int addr;
  } rpt_t;

  cyc_rec_t exp_q[$];
  rpt_t     obs_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic cyc_rec_t mk(input bit dn, input bit cs, input bit bz, input bit rv,
                                  input bit rt, input int idx, input int cyc, input bit ad,
                                  input int addr);
    cyc_rec_t r;
    r.done_in = dn;  r.go_in = 1'b0; r.cs = cs;   r.busy = bz; r.rv = rv;
    r.rt      = rt;  r.idx   = idx;  r.cyc = cyc; r.ad   = ad; r.addr = addr;
    return r;
  endfunction

  // lat = RUN cycle on which the core reports done (0 = never).
  task automatic build_seq(input int lat [NPROG], input bit stale [NPROG], input int go_at);
    int r_len;
    bit to;
    exp_q.delete();
    r_len = 0;
    for (int i = 0; i < NPROG; i++) begin
      to    = !(lat[i] != 0 && lat[i] <= TIMEOUT);
      r_len = to ? TIMEOUT : lat[i];
      for (int k = 0; k < START_CYC; k++)
        exp_q.push_back(mk(stale[i], 1, 1, 0, 0, i, 0, 0, EXP_ADDR[i]));
      for (int k = 1; k <= r_len; k++)
        exp_q.push_back(mk(k == lat[i], 0, 1, 0, 0, i, k - 1, 0, EXP_ADDR[i]));
      exp_q.push_back(mk(0, 1, 1, 1, to, i, r_len, 0, EXP_ADDR[i]));
    end
    exp_q.push_back(mk(0, 1, 0, 0, 0, NPROG - 1, r_len, 1, EXP_ADDR[NPROG-1]));
    if (go_at >= 0) exp_q[go_at].go_in = 1'b1;
  endtask

  task automatic run_seq(input int lat [NPROG], input bit stale [NPROG], input int go_at,
                         output int ad_cycle);
    cyc_rec_t r;
    rpt_t     o;
    int       c;
    string    t;
    build_seq(lat, stale, go_at);
    obs_q.delete();
    ad_cycle = -1;
    c = 0;
    @(negedge clk);
    bus.go = 1'b1;
    bus.core_done = 1'b0;
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      @(negedge clk);
      c++;
      t = $sformatf("c%0d", c);
      check({t, " core_start"},    32'(bus.core_start),    32'(r.cs));
      check({t, " busy"},          32'(bus.busy),          32'(r.busy));
      check({t, " rpt_valid"},     32'(bus.rpt_valid),     32'(r.rv));
      check({t, " rpt_timeout"},   32'(bus.rpt_timeout),   32'(r.rt));
      check({t, " prog_idx"},      32'(bus.prog_idx),      32'(r.idx));
      check({t, " cyc_count"},     32'(bus.cyc_count),     32'(r.cyc));
      check({t, " all_done"},      32'(bus.all_done),      32'(r.ad));
      check({t, " start_address"}, 32'(bus.start_address), 32'(r.addr));
      if (bus.rpt_valid === 1'b1) begin
        o.idx = int'(bus.prog_idx); o.cyc = int'(bus.cyc_count);
        o.to  = int'(bus.rpt_timeout); o.addr = int'(bus.start_address);
        obs_q.push_back(o);
        $display("[TB] report prog=%0d cyc=%0d timeout=%0d addr=%0d", o.idx, o.cyc, o.to, o.addr);
      end
      if (bus.all_done === 1'b1 && ad_cycle < 0) ad_cycle = c;
      bus.go        = r.go_in;
      bus.core_done = r.done_in;
    end
  endtask

  task automatic check_reports(input string tag, input int cyc [NPROG], input int to [NPROG]);
    check({tag, " report count"}, 32'(obs_q.size()), 32'(NPROG));
    for (int i = 0; i < NPROG && i < obs_q.size(); i++) begin
      check($sformatf("%s rpt%0d idx", tag, i),  32'(obs_q[i].idx),  32'(i));
      check($sformatf("%s rpt%0d cyc", tag, i),  32'(obs_q[i].cyc),  32'(cyc[i]));
      check($sformatf("%s rpt%0d to", tag, i),   32'(obs_q[i].to),   32'(to[i]));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " core_start"},    32'(bus.core_start),    32'd1);
    check({tag, " prog_idx"},      32'(bus.prog_idx),      32'd0);
    check({tag, " start_address"}, 32'(bus.start_address), 32'd0);
    check({tag, " cyc_count"},     32'(bus.cyc_count),     32'd0);
    check({tag, " rpt_valid"},     32'(bus.rpt_valid),     32'd0);
    check({tag, " rpt_timeout"},   32'(bus.rpt_timeout),   32'd0);
    check({tag, " busy"},          32'(bus.busy),          32'd0);
    check({tag, " all_done"},      32'(bus.all_done),      32'd0);
  endtask

  initial begin
    int  lat_a [NPROG] = '{10, 20, 5};
    int  lat_b [NPROG] = '{1, 0, 3};
    int  lat_d [NPROG] = '{2, 2, 2};
    bit  no_stale [NPROG] = '{0, 0, 0};
    bit  st_b [NPROG] = '{1, 0, 1};
    int  zeros [NPROG] = '{0, 0, 0};
    int  to_b [NPROG] = '{0, 1, 0};
    int  ad_cycle;

    bus.go = 1'b0;
    bus.core_done = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Normal run; program 1 finishes exactly at the watchdog limit, go pulsed mid-run.
    run_seq(lat_a, no_stale, 5, ad_cycle);
    check_reports("normal", lat_a, zeros);
    for (int i = 0; i < NPROG && i < obs_q.size(); i++)
      check($sformatf("normal rpt%0d addr", i), 32'(obs_q[i].addr), 32'(EXP_ADDR[i]));
    check("normal all_done cycle", 32'(ad_cycle), 32'd45);

    // Stale done through LAUNCH, watchdog on program 1; second go after all_done.
    run_seq(lat_b, st_b, -1, ad_cycle);
    check_reports("watchdog", '{1, 20, 3}, to_b);
    check("watchdog all_done cycle", 32'(ad_cycle), 32'd34);

    // Asynchronous reset in the middle of program 1's RUN phase.
    @(negedge clk);
    bus.go = 1'b1;
    bus.core_done = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (6) @(negedge clk);
    check("midrun prog_idx",      32'(bus.prog_idx),      32'd1);
    check("midrun busy",          32'(bus.busy),          32'd1);
    check("midrun core_start",    32'(bus.core_start),    32'd0);
    check("midrun start_address", 32'(bus.start_address), 32'd64);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async reset");
    bus.core_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_seq(lat_d, no_stale, -1, ad_cycle);
    check_reports("after reset", lat_d, zeros);
    check("after reset all_done cycle", 32'(ad_cycle), 32'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
